// File: rtl/ysyx_22040237_wbu.sv
// ysyx_22040237_wbu : writeback / commit unit.
// Accepts one execute-stage result per handshake. Owns the architectural state:
// the 32x64 integer register file, the PC and the retire counter.
// Also runs the halt state machine: RUN, then END on ebreak or ABORT on an
// invalid instruction or a misaligned jump target.
// Optional feature macro: YSYX_22040237_WBU_BYPASS_EN. When defined, a write
// committed in the current cycle is forwarded combinationally to the read ports.
module ysyx_22040237_wbu #(
    parameter int              XLEN     = 64,
    parameter int              CNT_W    = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_rd_wen,
    input  logic [4:0]       ex_rd_addr,
    input  logic [XLEN-1:0]  ex_rd_data,
    input  logic             ex_jump,
    input  logic [XLEN-1:0]  ex_jump_addr,
    input  logic             ex_ebreak,
    input  logic             ex_invalid,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    output logic [XLEN-1:0]  halt_code,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_END   = 2'b01,
        ST_ABORT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(3'd4);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1'b1);

    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   halt_code_r;
    logic              halted_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   regs_r [0:31];

    logic              ready_s;
    logic              commit_s;
    logic [XLEN-1:0]   jump_tgt_s;
    logic              misalign_s;
    logic              abort_s;
    logic              end_s;
    logic              normal_s;
    logic              wr_s;
    logic [XLEN-1:0]   pc_next_s;
    logic [XLEN-1:0]   rs1_data_s;
    logic [XLEN-1:0]   rs2_data_s;

    // Classify the offered result; priority is invalid > misaligned jump > ebreak > normal.
    always_comb begin
        ready_s    = (state_r == ST_RUN);
        commit_s   = ex_valid & ready_s;
        jump_tgt_s = {ex_jump_addr[XLEN-1:1], 1'b0};
        misalign_s = ex_jump & jump_tgt_s[1];
        abort_s    = commit_s & (ex_invalid | misalign_s);
        end_s      = commit_s & ~ex_invalid & ~misalign_s & ex_ebreak;
        normal_s   = commit_s & ~ex_invalid & ~misalign_s & ~ex_ebreak;
        wr_s       = normal_s & ex_rd_wen & (ex_rd_addr != 5'd0);
        if (ex_jump) begin
            pc_next_s = jump_tgt_s;
        end else begin
            pc_next_s = ex_pc + PC_STEP;
        end
    end

    // Read port 1: x0 is hard zero, optional same-cycle forwarding of the committing write.
    always_comb begin
        rs1_data_s = '0;
        if (rs1_addr == 5'd0) begin
            rs1_data_s = '0;
`ifdef YSYX_22040237_WBU_BYPASS_EN
        end else if (wr_s && (rs1_addr == ex_rd_addr)) begin
            rs1_data_s = ex_rd_data;
`endif
        end else begin
            rs1_data_s = regs_r[rs1_addr];
        end
    end

    // Read port 2: same behaviour as read port 1.
    always_comb begin
        rs2_data_s = '0;
        if (rs2_addr == 5'd0) begin
            rs2_data_s = '0;
`ifdef YSYX_22040237_WBU_BYPASS_EN
        end else if (wr_s && (rs2_addr == ex_rd_addr)) begin
            rs2_data_s = ex_rd_data;
`endif
        end else begin
            rs2_data_s = regs_r[rs2_addr];
        end
    end

    // Register file storage; entry 0 is cleared on reset and never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_s) begin
            regs_r[ex_rd_addr] <= ex_rd_data;
        end else begin
            regs_r[ex_rd_addr] <= regs_r[ex_rd_addr];
        end
    end

    // Halt FSM with PC, retire counter and halt outputs; END and ABORT hold until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            pc_r        <= RESET_PC;
            cnt_r       <= '0;
            halted_r    <= 1'b0;
            halt_code_r <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (abort_s) begin
                        state_r     <= ST_ABORT;
                        halted_r    <= 1'b1;
                        halt_code_r <= '1;
                    end else if (end_s) begin
                        // ebreak never writes rd, so x10 still holds the pre-commit value
                        state_r     <= ST_END;
                        halted_r    <= 1'b1;
                        halt_code_r <= regs_r[10];
                        cnt_r       <= cnt_r + CNT_STEP;
                    end else if (normal_s) begin
                        pc_r        <= pc_next_s;
                        cnt_r       <= cnt_r + CNT_STEP;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                ST_END, ST_ABORT: begin
                    state_r <= state_r;
                end
                default: begin
                    // unreachable encoding: fail safe into ABORT
                    state_r     <= ST_ABORT;
                    halted_r    <= 1'b1;
                    halt_code_r <= '1;
                end
            endcase
        end
    end

    assign ex_ready   = ready_s;
    assign rs1_data   = rs1_data_s;
    assign rs2_data   = rs2_data_s;
    assign pc         = pc_r;
    assign halted     = halted_r;
    assign halt_code  = halt_code_r;
    assign state_o    = state_r;
    assign retire_cnt = cnt_r;

endmodule

// File: tb/tb_ysyx_22040237_wbu.sv
// Scoreboard testbench for ysyx_22040237_wbu: directed cases plus randomized episodes
// checked against a behavioural architectural-state model.
module tb_ysyx_22040237_wbu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_pc;
    logic        ex_rd_wen;
    logic [4:0]  ex_rd_addr;
    logic [63:0] ex_rd_data;
    logic        ex_jump;
    logic [63:0] ex_jump_addr;
    logic        ex_ebreak;
    logic        ex_invalid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] pc;
    logic        halted;
    logic [63:0] halt_code;
    logic [1:0]  state_o;
    logic [63:0] retire_cnt;

    ysyx_22040237_wbu dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rd_wen(ex_rd_wen), .ex_rd_addr(ex_rd_addr), .ex_rd_data(ex_rd_data),
        .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
        .ex_ebreak(ex_ebreak), .ex_invalid(ex_invalid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .halted(halted), .halt_code(halt_code),
        .state_o(state_o), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  st;
        logic [63:0] code;
        logic [63:0] cnt;
        logic        halted;
        logic        ready;
        logic [4:0]  raddr;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // architectural model: 0 = RUN, 1 = END, 2 = ABORT
    logic [63:0] m_reg [32];
    logic [63:0] m_pc;
    logic [63:0] m_code;
    logic [63:0] m_cnt;
    int          m_state;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
        m_pc = RST_PC; m_code = 64'd0; m_cnt = 64'd0; m_state = 0;
    endtask

    // Drive one cycle of input, advance the model, and queue the expected post-edge state.
    task automatic drive(input logic v, input logic [63:0] p, input logic w, input logic [4:0] rd,
                         input logic [63:0] d, input logic j, input logic [63:0] ja,
                         input logic eb, input logic inv, input logic [4:0] ra);
        exp_t e;
        logic [63:0] tgt;
        @(negedge clk);
        ex_valid = v; ex_pc = p; ex_rd_wen = w; ex_rd_addr = rd; ex_rd_data = d;
        ex_jump = j; ex_jump_addr = ja; ex_ebreak = eb; ex_invalid = inv; rs2_addr = ra;
        tgt = ja & ~64'd1;
        if (v && m_state == 0) begin
            if (inv || (j && tgt[1])) begin
                m_state = 2; m_code = ~64'd0;
            end else if (eb) begin
                m_state = 1; m_code = m_reg[10]; m_cnt = m_cnt + 64'd1;
            end else begin
                if (w && rd != 5'd0) m_reg[rd] = d;
                m_pc  = j ? tgt : p + 64'd4;
                m_cnt = m_cnt + 64'd1;
            end
        end
        e.pc = m_pc; e.st = 2'(m_state); e.code = m_code; e.cnt = m_cnt;
        e.halted = (m_state != 0); e.ready = (m_state == 0);
        e.raddr = ra; e.rdata = m_reg[ra];
        sb.push_back(e);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [63:0] d);
        drive(1'b1, m_pc, 1'b1, rd, d, 1'b0, 64'd0, 1'b0, 1'b0, rd);
    endtask

    task automatic drain();
        @(negedge clk);
        ex_valid = 1'b0;
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ex_valid = 1'b0;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare DUT state one delta after each edge with the oldest queued expectation.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("pc",         pc,                 mon_e.pc);
            chk("state",      64'(state_o),       64'(mon_e.st));
            chk("halt_code",  halt_code,          mon_e.code);
            chk("retire_cnt", retire_cnt,         mon_e.cnt);
            chk("halted",     64'(halted),        64'(mon_e.halted));
            chk("ex_ready",   64'(ex_ready),      64'(mon_e.ready));
            chk("rs2_data",   rs2_data,           mon_e.rdata);
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_pc = 64'd0; ex_rd_wen = 1'b0; ex_rd_addr = 5'd0;
        ex_rd_data = 64'd0; ex_jump = 1'b0; ex_jump_addr = 64'd0; ex_ebreak = 1'b0;
        ex_invalid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        // reset state
        chk("rst_pc", pc, RST_PC);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        chk("rst_cnt", retire_cnt, 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_code", halt_code, 64'd0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            #1;
            chk("rst_rs1", rs1_data, 64'd0);
        end
        rs1_addr = 5'd5;

        // first commit
        wr(5'd5, 64'h1234);
        drain();
        chk("first_pc", pc, 64'h8000_0004);
        chk("first_x5", rs1_data, 64'h1234);
        chk("first_cnt", retire_cnt, 64'd1);

        // x0 write and PC wrap
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 5'd0, 64'hDEAD, 1'b0, 64'd0, 1'b0, 1'b0, 5'd0);
        drain();
        rs1_addr = 5'd0;
        #1;
        chk("x0_zero", rs1_data, 64'd0);
        chk("wrap_pc", pc, 64'd0);

        // jumps: odd target is rounded down, bit1 set aborts
        drive(1'b1, m_pc, 1'b0, 5'd0, 64'd0, 1'b1, 64'h8000_0011, 1'b0, 1'b0, 5'd5);
        drain();
        chk("jump_pc", pc, 64'h8000_0010);
        drive(1'b1, m_pc, 1'b0, 5'd0, 64'd0, 1'b1, 64'h8000_0012, 1'b0, 1'b0, 5'd5);
        drain();
        chk("mis_state", 64'(state_o), 64'd2);
        chk("mis_code", halt_code, ~64'd0);
        chk("mis_pc", pc, 64'h8000_0010);
        chk("mis_ready", 64'(ex_ready), 64'd0);

        // ebreak good trap, then ignored pulses
        do_reset();
        wr(5'd10, 64'd0);
        drive(1'b1, m_pc, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 5'd10);
        for (int k = 0; k < 3; k++) wr(5'd10, 64'd9);
        drain();
        chk("eb0_state", 64'(state_o), 64'd1);
        chk("eb0_code", halt_code, 64'd0);
        chk("eb0_cnt", retire_cnt, 64'd2);

        // ebreak bad trap
        do_reset();
        wr(5'd10, 64'd7);
        drive(1'b1, m_pc, 1'b1, 5'd10, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 5'd10);
        drain();
        chk("eb7_code", halt_code, 64'd7);

        // invalid beats ebreak
        do_reset();
        wr(5'd3, 64'hAB);
        drive(1'b1, m_pc, 1'b1, 5'd3, 64'hFF, 1'b0, 64'd0, 1'b1, 1'b1, 5'd3);
        drain();
        chk("inv_state", 64'(state_o), 64'd2);
        chk("inv_x3", rs2_data, 64'hAB);
        chk("inv_cnt", retire_cnt, 64'd1);

        // bypass visibility within the writing cycle
        do_reset();
        wr(5'd8, 64'h11);
        rs1_addr = 5'd8;
        wr(5'd8, 64'h55);
        #1;
`ifdef YSYX_22040237_WBU_BYPASS_EN
        chk("bypass_rs1", rs1_data, 64'h55);
`else
        chk("bypass_rs1", rs1_data, 64'h11);
`endif
        drain();

        // reset mid-commit discards the commit immediately
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = m_pc; ex_rd_wen = 1'b1; ex_rd_addr = 5'd6; ex_rd_data = 64'h77;
        ex_jump = 1'b0; ex_ebreak = 1'b0; ex_invalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_pc", pc, RST_PC);
        chk("mid_cnt", retire_cnt, 64'd0);
        chk("mid_x8", rs1_data, 64'd0);
        chk("mid_state", 64'(state_o), 64'd0);
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0; rs2_addr = 5'd6;
        m_reset();
        #1;
        chk("mid_x6", rs2_data, 64'd0);
        chk("mid_pc2", pc, RST_PC);

        // randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                logic        v, w, j, eb, inv;
                logic [4:0]  rd, ra;
                logic [63:0] d, ja, p;
                v   = ($urandom_range(0, 9) != 0);
                w   = ($urandom_range(0, 9) < 7);
                rd  = 5'($urandom_range(0, 31));
                ra  = 5'($urandom_range(0, 31));
                d   = {$urandom, $urandom};
                j   = ($urandom_range(0, 4) == 0);
                ja  = {$urandom, $urandom};
                if ($urandom_range(0, 19) != 0) ja[1] = 1'b0;
                eb  = ($urandom_range(0, 99) < 2);
                inv = ($urandom_range(0, 99) < 2);
                p   = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : m_pc;
                rs1_addr = 5'($urandom_range(0, 31));
                drive(v, p, w, rd, d, j, ja, eb, inv, ra);
                if (m_state != 0 && $urandom_range(0, 3) == 0) break;
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_wbu.md
Name: ysyx_22040237_wbu

Overview:
- Writeback/commit unit. Receiving end of the execute-stage result interface.
- Accepts one result per handshake from the EXU: rd_data, pc_jump_addr, ebreak and invalid-instruction flags.
- Owns the architectural state: 32x64 integer register file, PC register, retire counter.
- Runs the halt state machine that ends simulation on ebreak (good/bad trap via a0) or on an invalid instruction or misaligned target (abort).

Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.
- XLEN, 64, register and PC width.
- CNT_W, 64, width of the retire counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EXU result valid.
- ex_ready  output  1  WBU can accept a result.
- ex_pc  input  XLEN  PC of the committing instruction.
- ex_rd_wen  input  1  write rd.
- ex_rd_addr  input  5  destination register.
- ex_rd_data  input  XLEN  result (EXU rd_data).
- ex_jump  input  1  take pc_jump_addr.
- ex_jump_addr  input  XLEN  EXU pc_jump_addr.
- ex_ebreak  input  1  instruction is ebreak.
- ex_invalid  input  1  instruction failed decode.
- rs1_addr  input  5  read port 1 address.
- rs2_addr  input  5  read port 2 address.
- rs1_data  output  XLEN  read port 1 data, combinational.
- rs2_data  output  XLEN  read port 2 data, combinational.
- pc  output  XLEN  current fetch PC.
- halted  output  1  machine stopped.
- halt_code  output  XLEN  0 = good trap; nonzero a0 = bad trap; all-ones = abort.
- state_o  output  2  00 RUN, 01 END, 10 ABORT.
- retire_cnt  output  CNT_W  committed instruction count.

Behaviour:
- Reset (async, immediate on rst high):
  - pc = RESET_PC; x1..x31 = 0; retire_cnt = 0.
  - state = RUN; halted = 0; halt_code = 0; ex_ready = 1.
  - Reset mid-commit discards that commit entirely.
- Commit:
  - commit = ex_valid & ex_ready; takes effect at the posedge.
  - ex_ready = (state == RUN), combinational, independent of ex_valid.
- Register file:
  - x0 reads 0 always; writes to x0 are dropped.
  - Write occurs on commit & ex_rd_wen & (ex_rd_addr != 0) & no halt condition this commit.
  - Reads are asynchronous. Without bypass, a same-cycle write is not visible until the next cycle.
- PC update on a normal commit:
  - If ex_jump: pc = {ex_jump_addr[XLEN-1:1], 1'b0}. Bit 0 is cleared (jalr semantics).
  - Otherwise: pc = ex_pc + 4, modulo 2^XLEN. 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- retire_cnt:
  - Increments by 1 on every commit, including the ebreak commit. Aborting commits do not count.
  - Wraps at 2^CNT_W.
- Priority within a single commit: ex_invalid > misaligned jump > ebreak > normal.
- RUN -> ABORT, on commit & ex_invalid:
  - No register write, pc unchanged.
  - halt_code = all-ones; halted = 1 on the next cycle.
- RUN -> ABORT, on commit & ex_jump & masked target bit[1] == 1:
  - Misaligned target (no C extension). Same effects as invalid.
- RUN -> END, on commit & ex_ebreak:
  - halt_code = value of x10 before this commit (ebreak never writes rd).
  - pc unchanged; halted = 1.
- END and ABORT:
  - Terminal until rst; ex_ready = 0.
  - ex_valid is ignored; no state changes.
- Read ports stay functional in all states, so the bench can dump registers after a halt.
- A commit with ex_valid low changes nothing.

Optional Feature:
- Macro: YSYX_22040237_WBU_BYPASS_EN.
- Defined: a read address matching a qualifying write in the same cycle (commit, wen, addr != 0, no halt) returns ex_rd_data combinationally. x0 is never bypassed.
- Undefined: no bypass; reads return the stored value.

Test Plan:
- Reset and first commit:
  - Stimulus: assert rst, then release it.
  - Required: pc = 0x8000_0000; rs1_data = 0 for all addresses; ex_ready = 1; retire_cnt = 0.
  - Stimulus: commit ex_pc = 0x8000_0000, wen, rd = 5, data = 0x1234.
  - Required: pc = 0x8000_0004; x5 = 0x1234; retire_cnt = 1.
- x0 write and PC wrap:
  - Stimulus: commit wen, rd = 0, data = 0xDEAD, ex_pc = 0xFFFF_FFFF_FFFF_FFFC.
  - Required: x0 reads 0; pc = 0.
- Jumps:
  - Stimulus: commit ex_jump, addr = 0x8000_0011.
  - Required: pc = 0x8000_0010.
  - Stimulus: then commit ex_jump, addr = 0x8000_0012.
  - Required: state_o = ABORT; halt_code = all-ones; pc stays 0x8000_0010; ex_ready = 0.
- ebreak:
  - Stimulus: set x10 = 0, commit ex_ebreak.
  - Required: state_o = END; halt_code = 0; retire_cnt incremented.
  - Stimulus: set x10 = 7, then ebreak.
  - Required: halt_code = 7.
  - Stimulus: further ex_valid pulses.
  - Required: ignored.
- Invalid wins over ebreak:
  - Stimulus: commit ex_invalid and ex_ebreak together, with wen rd = 3.
  - Required: ABORT; x3 unchanged; retire_cnt unchanged.
- Bypass and reset mid-operation:
  - Stimulus: commit wen rd = 8, data = 0x55 while rs1_addr = 8.
  - Required: rs1_data = 0x55 in that cycle with YSYX_22040237_WBU_BYPASS_EN defined; old value without it.
  - Stimulus: assert rst mid-cycle during a commit.
  - Required: all state returns to reset values immediately.
